// File: rtl/hit_time_credit.sv
// hit_time_credit
// Hit qualifier and time-credit generator for the whack-a-mole game core.
// It watches the hole buttons for new presses and judges each press against
// the moles that are up while the game is in POP. A hit produces a one-cycle
// add-time pulse carrying the credit, which includes a combo bonus on every
// COMBO_LEN-th consecutive hit. Hit, miss and combo counts are kept for the
// score display.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   hamster_op   level press per hole, already synchronised (1 = pressed)
//   mole_mask    1 = mole up in that hole
//   state        game FSM state; presses are judged only in `POP
//   clr          synchronous clear of counters, combo and lockout (new game)
//   add_time_en  one-cycle pulse per qualified hit
//   add_time_amt credit for the hit, 0 when no pulse
//   hit_mask     holes hit in the judged event, 0 when no pulse
//   hit_cnt      total hits, saturating
//   miss_cnt     total misses, saturating
//   combo        current consecutive-hit streak, saturating

`ifndef POP
`define POP 2'd2
`endif

module hit_time_credit #(
    parameter int N_HOLES     = 10,
    parameter int CNT_W       = 8,
    parameter int AMT_W       = 4,
    parameter int BASE_TIME   = 1,
    parameter int BONUS_TIME  = 2,
    parameter int COMBO_LEN   = 3,
    parameter int LOCKOUT_CYC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_HOLES-1:0] hamster_op,
    input  logic [N_HOLES-1:0] mole_mask,
    input  logic [1:0]         state,
    input  logic               clr,
    output logic               add_time_en,
    output logic [AMT_W-1:0]   add_time_amt,
    output logic [N_HOLES-1:0] hit_mask,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt,
    output logic [CNT_W-1:0]   combo
);

    localparam int LK_W = (LOCKOUT_CYC > 0) ? $clog2(LOCKOUT_CYC + 1) : 1;
    localparam int PH_W = (COMBO_LEN > 1) ? $clog2(COMBO_LEN) : 1;

    logic [N_HOLES-1:0] press_prev_q;
    logic [LK_W-1:0]    lock_q, lock_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]   combo_q, combo_d;
    logic               en_q, en_d;
    logic [AMT_W-1:0]   amt_q, amt_d;
    logic [N_HOLES-1:0] hmask_q, hmask_d;

    logic [N_HOLES-1:0] rise;
    logic [N_HOLES-1:0] rise_hit;
    logic               judge;
    logic               is_hit;
    logic               wrap;

    assign rise     = hamster_op & ~press_prev_q;
    assign rise_hit = rise & mole_mask;
    // Any number of holes rising in one cycle is a single judged event.
    assign judge    = (state == `POP) && !clr && (lock_q == '0) && (rise != '0);
    assign is_hit   = (rise_hit != '0);
    // The phase runs independently of the saturating combo count, so bonuses
    // keep coming even after combo pins at all-ones.
    assign wrap     = (phase_q == PH_W'(COMBO_LEN - 1));

    always_comb begin
        lock_d     = lock_q;
        phase_d    = phase_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        combo_d    = combo_q;
        en_d       = 1'b0;
        amt_d      = '0;
        hmask_d    = '0;

        if (lock_q != '0) begin
            lock_d = lock_q - LK_W'(1);
        end

        if (clr) begin
            lock_d     = '0;
            phase_d    = '0;
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
            combo_d    = '0;
        end else if (judge) begin
            lock_d = LK_W'(LOCKOUT_CYC);
            if (is_hit) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                if (combo_q != '1)   combo_d   = combo_q + CNT_W'(1);
                phase_d = wrap ? '0 : phase_q + PH_W'(1);
                en_d    = 1'b1;
                hmask_d = rise_hit;
                amt_d   = wrap ? AMT_W'(BASE_TIME) + AMT_W'(BONUS_TIME)
                               : AMT_W'(BASE_TIME);
            end else begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                combo_d = '0;
                phase_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_prev_q <= '0;
            lock_q       <= '0;
            phase_q      <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            combo_q      <= '0;
            en_q         <= 1'b0;
            amt_q        <= '0;
            hmask_q      <= '0;
        end else begin
            // Tracks the buttons every cycle so a press held across a state
            // change never looks like a fresh edge.
            press_prev_q <= hamster_op;
            lock_q       <= lock_d;
            phase_q      <= phase_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            combo_q      <= combo_d;
            en_q         <= en_d;
            amt_q        <= amt_d;
            hmask_q      <= hmask_d;
        end
    end

    assign add_time_en  = en_q;
    assign add_time_amt = amt_q;
    assign hit_mask     = hmask_q;
    assign hit_cnt      = hit_cnt_q;
    assign miss_cnt     = miss_cnt_q;
    assign combo        = combo_q;

endmodule

// File: tb/tb_hit_time_credit.sv
`ifndef POP
`define POP 2'd2
`endif

module tb_hit_time_credit;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_POP  = `POP;

    logic       clk;
    logic       rst_n;
    logic [9:0] hamster_op;
    logic [9:0] mole_mask;
    logic [1:0] state;
    logic       clr;
    logic       add_time_en;
    logic [3:0] add_time_amt;
    logic [9:0] hit_mask;
    logic [7:0] hit_cnt;
    logic [7:0] miss_cnt;
    logic [7:0] combo;

    int checks;
    int errors;

    hit_time_credit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hamster_op   (hamster_op),
        .mole_mask    (mole_mask),
        .state        (state),
        .clr          (clr),
        .add_time_en  (add_time_en),
        .add_time_amt (add_time_amt),
        .hit_mask     (hit_mask),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt),
        .combo        (combo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press a pattern: outputs after this reflect the judgement of the press.
    task automatic press(input logic [9:0] v);
        hamster_op = v;
        tick();
    endtask

    // Release all buttons and let the lockout run out.
    task automatic release_wait(input int n);
        hamster_op = '0;
        repeat (n) tick();
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hamster_op = '0; mole_mask = '0; state = ST_IDLE; clr = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({add_time_en, add_time_amt, hit_mask, hit_cnt, miss_cnt, combo} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%0b amt=%0d hm=%h hit=%0d miss=%0d combo=%0d, want all 0",
                     add_time_en, add_time_amt, hit_mask, hit_cnt, miss_cnt, combo);
        end
    endtask

    task automatic test_first_hit();
        state = ST_POP; mole_mask = 10'h004;
        tick();
        press(10'h004);
        checks++;
        if ({add_time_en, add_time_amt, hit_mask, hit_cnt, combo} !== {1'b1, 4'd1, 10'h004, 8'd1, 8'd1}) begin
            errors++;
            $display("FAIL first_hit: got en=%0b amt=%0d hm=%h hit=%0d combo=%0d, want 1 1 004 1 1",
                     add_time_en, add_time_amt, hit_mask, hit_cnt, combo);
        end
        tick();
        checks++;
        if ({add_time_en, add_time_amt, hit_mask} !== '0) begin
            errors++;
            $display("FAIL pulse_width: got en=%0b amt=%0d hm=%h, want 0 0 000",
                     add_time_en, add_time_amt, hit_mask);
        end
        release_wait(5);
    endtask

    task automatic test_combo();
        logic [3:0] exp_amt [4];
        exp_amt[0] = 4'd1; exp_amt[1] = 4'd1; exp_amt[2] = 4'd3; exp_amt[3] = 4'd1;
        do_clear();
        state = ST_POP; mole_mask = 10'h010;
        for (int i = 0; i < 4; i++) begin
            press(10'h010);
            checks++;
            if (add_time_en !== 1'b1 || add_time_amt !== exp_amt[i] || combo !== 8'(i + 1)) begin
                errors++;
                $display("FAIL combo_hit%0d: got en=%0b amt=%0d combo=%0d, want 1 %0d %0d",
                         i, add_time_en, add_time_amt, combo, exp_amt[i], i + 1);
            end
            release_wait(5);
        end
        mole_mask = 10'h001;
        press(10'h020);
        checks++;
        if (add_time_en !== 1'b0 || miss_cnt !== 8'd1 || combo !== 8'd0 || hit_cnt !== 8'd4) begin
            errors++;
            $display("FAIL combo_miss: got en=%0b miss=%0d combo=%0d hit=%0d, want 0 1 0 4",
                     add_time_en, miss_cnt, combo, hit_cnt);
        end
        release_wait(5);
        // Phase restarted by the miss: the next three hits give 1,1,3 again.
        press(10'h001); release_wait(5);
        press(10'h001); release_wait(5);
        press(10'h001);
        checks++;
        if (add_time_amt !== 4'd3 || combo !== 8'd3) begin
            errors++;
            $display("FAIL combo_after_miss: got amt=%0d combo=%0d, want 3 3", add_time_amt, combo);
        end
        release_wait(5);
    endtask

    task automatic test_lockout();
        do_clear();
        state = ST_POP; mole_mask = 10'h002;
        press(10'h002);
        release_wait(1);
        press(10'h002);
        checks++;
        if (add_time_en !== 1'b0 || hit_cnt !== 8'd1 || miss_cnt !== 8'd0) begin
            errors++;
            $display("FAIL lockout_ignore: got en=%0b hit=%0d miss=%0d, want 0 1 0",
                     add_time_en, hit_cnt, miss_cnt);
        end
        release_wait(2);
        press(10'h002);
        checks++;
        if (add_time_en !== 1'b1 || hit_cnt !== 8'd2) begin
            errors++;
            $display("FAIL lockout_expire: got en=%0b hit=%0d, want 1 2", add_time_en, hit_cnt);
        end
        release_wait(5);
    endtask

    task automatic test_held_button();
        do_clear();
        state = ST_IDLE; mole_mask = 10'h040;
        press(10'h040);
        checks++;
        if (add_time_en !== 1'b0 || hit_cnt !== 8'd0 || miss_cnt !== 8'd0) begin
            errors++;
            $display("FAIL idle_press: got en=%0b hit=%0d miss=%0d, want 0 0 0",
                     add_time_en, hit_cnt, miss_cnt);
        end
        tick();
        state = ST_POP;
        repeat (2) tick();
        checks++;
        if (add_time_en !== 1'b0 || hit_cnt !== 8'd0) begin
            errors++;
            $display("FAIL held_into_pop: got en=%0b hit=%0d, want 0 0", add_time_en, hit_cnt);
        end
        release_wait(1);
        press(10'h040);
        checks++;
        if (add_time_en !== 1'b1 || hit_cnt !== 8'd1 || hit_mask !== 10'h040) begin
            errors++;
            $display("FAIL held_repress: got en=%0b hit=%0d hm=%h, want 1 1 040",
                     add_time_en, hit_cnt, hit_mask);
        end
        release_wait(5);
    endtask

    task automatic test_multi_rise();
        do_clear();
        state = ST_POP; mole_mask = 10'h008;
        press(10'h00A);
        checks++;
        if (add_time_en !== 1'b1 || hit_mask !== 10'h008 || hit_cnt !== 8'd1 || add_time_amt !== 4'd1) begin
            errors++;
            $display("FAIL multi_hit: got en=%0b hm=%h hit=%0d amt=%0d, want 1 008 1 1",
                     add_time_en, hit_mask, hit_cnt, add_time_amt);
        end
        release_wait(5);
        mole_mask = 10'h000;
        press(10'h00A);
        checks++;
        if (add_time_en !== 1'b0 || miss_cnt !== 8'd1 || hit_cnt !== 8'd1 || combo !== 8'd0) begin
            errors++;
            $display("FAIL multi_miss: got en=%0b miss=%0d hit=%0d combo=%0d, want 0 1 1 0",
                     add_time_en, miss_cnt, hit_cnt, combo);
        end
        release_wait(5);
    endtask

    task automatic test_clr_and_saturation();
        state = ST_POP; mole_mask = 10'h004;
        hamster_op = 10'h004; clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if ({add_time_en, hit_cnt, miss_cnt, combo} !== '0) begin
            errors++;
            $display("FAIL clr_override: got en=%0b hit=%0d miss=%0d combo=%0d, want 0 0 0 0",
                     add_time_en, hit_cnt, miss_cnt, combo);
        end
        release_wait(1);
        for (int i = 0; i < 255; i++) begin
            press(10'h004);
            release_wait(5);
        end
        checks++;
        if (hit_cnt !== 8'hFF || combo !== 8'hFF) begin
            errors++;
            $display("FAIL sat_reach: got hit=%h combo=%h, want ff ff", hit_cnt, combo);
        end
        press(10'h004);
        checks++;
        if (add_time_en !== 1'b1 || add_time_amt !== 4'd1 || hit_cnt !== 8'hFF || combo !== 8'hFF) begin
            errors++;
            $display("FAIL sat_hold: got en=%0b amt=%0d hit=%h combo=%h, want 1 1 ff ff",
                     add_time_en, add_time_amt, hit_cnt, combo);
        end
        release_wait(5);
        press(10'h004); release_wait(5);
        press(10'h004);
        checks++;
        if (add_time_en !== 1'b1 || add_time_amt !== 4'd3) begin
            errors++;
            $display("FAIL sat_bonus: got en=%0b amt=%0d, want 1 3", add_time_en, add_time_amt);
        end
        release_wait(5);
    endtask

    task automatic test_async_reset();
        do_clear();
        state = ST_POP; mole_mask = 10'h100;
        press(10'h100);
        checks++;
        if (add_time_en !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pulse: got en=%0b, want 1", add_time_en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({add_time_en, add_time_amt, hit_mask, hit_cnt, combo} !== '0) begin
            errors++;
            $display("FAIL async_reset: got en=%0b amt=%0d hm=%h hit=%0d combo=%0d, want all 0",
                     add_time_en, add_time_amt, hit_mask, hit_cnt, combo);
        end
        hamster_op = '0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (add_time_en !== 1'b0 || hit_cnt !== 8'd0) begin
            errors++;
            $display("FAIL after_reset: got en=%0b hit=%0d, want 0 0", add_time_en, hit_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_first_hit();
        test_combo();
        test_lockout();
        test_held_button();
        test_multi_rise();
        test_clr_and_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hit_time_credit.md
Name: hit_time_credit

Overview:
Parametrised hit qualifier and time-credit generator for the whack-a-mole game core. It samples N hole buttons, detects press edges, and judges each press against the mask of moles currently up while the game FSM is in POP. It emits a one-cycle add-time pulse with a credit amount, including combo bonuses, and maintains hit, miss and combo counters for the score display.

Parameters:
N_HOLES, 10, number of holes/buttons
CNT_W, 8, width of hit_cnt, miss_cnt, combo
AMT_W, 4, width of add_time_amt; must hold BASE_TIME+BONUS_TIME
BASE_TIME, 1, credit per qualified hit
BONUS_TIME, 2, extra credit on every COMBO_LEN-th consecutive hit
COMBO_LEN, 3, streak length for bonus (>=1)
LOCKOUT_CYC, 4, cycles after any judged event during which new edges are ignored; 0 disables

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
hamster_op  in  N_HOLES  level press per hole, 1=pressed, synchronised upstream
mole_mask  in  N_HOLES  1=mole up in that hole
state  in  2  game FSM state; events judged only when state == `POP (global definitions)
clr  in  1  synchronous clear of counters/combo/lockout (new game)
add_time_en  out  1  one-cycle pulse per qualified hit
add_time_amt  out  AMT_W  credit amount, valid when add_time_en=1, else 0
hit_mask  out  N_HOLES  holes hit in the judged event, valid with add_time_en, else 0
hit_cnt  out  CNT_W  total hits, saturating
miss_cnt  out  CNT_W  total misses, saturating
combo  out  CNT_W  current consecutive-hit streak, saturating

Behaviour:
- Reset (rst_n=0, async): press_prev, lockout counter, combo phase, all outputs = 0.
- Edge detect: press_prev <= hamster_op every cycle, regardless of state/clr/lockout; rise = hamster_op & ~press_prev. A button held while entering POP produces no event.
- Lockout: counter loaded with LOCKOUT_CYC on every judged event; decrements to 0 each cycle in any state; rises seen while counter != 0 are discarded, not counted.
- Judged event: state==`POP, clr=0, lockout==0, rise!=0. One event per cycle regardless of how many holes rose.
  - Hit if (rise & mole_mask) != 0; miss otherwise.
- Hit: hit_cnt+1 (saturating at all-ones); combo+1 (saturating); combo phase +1, wrapping to 0 at COMBO_LEN. Next cycle: add_time_en=1, hit_mask=rise&mole_mask, add_time_amt=BASE_TIME, plus BONUS_TIME if the phase wrapped on this hit.
- Miss: miss_cnt+1 (saturating); combo=0; phase=0; no pulse.
- Latency: add_time_en and counters update on the clock edge after rise is sampled (1 cycle). add_time_en never exceeds 1 cycle; back-to-back pulses are possible only when LOCKOUT_CYC=0.
- Outside POP: no judgement; counters, combo and phase hold; outputs pulse-free.
- clr=1: hit_cnt, miss_cnt, combo, phase, lockout <= 0; add_time_en, add_time_amt, hit_mask <= 0; clr overrides any same-cycle event.
- Saturation: combo saturation does not stop phase wrapping; bonuses continue every COMBO_LEN hits.
- Async reset mid-pulse: outputs drop immediately; no pending credit survives.

Test Plan:
- Reset then POP, mole_mask=10'h004, hamster_op 0->10'h004 -> one cycle later add_time_en=1 for exactly 1 cycle, amt=1, hit_mask=10'h004, hit_cnt=1, combo=1.
- Three hits spaced >=5 cycles apart -> amts 1,1,3; combo=3; 4th hit amt=1. Then a miss (press hole with mask bit 0) -> miss_cnt=1, combo=0, no pulse.
- Hit followed by a second rise 2 cycles later -> second ignored (counters unchanged); rise 5 cycles after the hit is judged.
- Button held from a non-POP state into POP with the mole up -> no event; release and re-press -> hit.
- Simultaneous rise on holes 1 and 3, mask=10'h008 -> single hit, hit_mask=10'h008, hit_cnt+1; with mask=0 -> single miss.
- clr asserted in the same cycle as a qualifying rise -> all counters 0, no pulse; hit_cnt at 8'hFF plus one hit -> stays 8'hFF, pulse still issued.
